// File: rtl/pkg_masina.sv
// Shared encodings for the line-follower direction controller: FSM states,
// motor direction codes, last-seen-line codes and the registered command payload.
package pkg_masina;

    typedef enum logic [2:0] {
        ST_FOLLOW  = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_REVERSE = 3'd2,
        ST_STOP    = 3'd3
    } stare_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_DR   = 2'd1,
        DIR_ST   = 2'd2
    } ultima_t;

    localparam logic [1:0] MOT_FWD  = 2'b10;
    localparam logic [1:0] MOT_REV  = 2'b01;
    localparam logic [1:0] MOT_HALT = 2'b00;

    typedef struct packed {
        logic [1:0] drv_a;
        logic [1:0] drv_b;
        logic       sig_dr;
        logic       sig_st;
    } comanda_t;

    // Opposite side for the next sweep; NONE has no opposite.
    function automatic ultima_t flip_dir(input ultima_t d);
        case (d)
            DIR_DR:  flip_dir = DIR_ST;
            DIR_ST:  flip_dir = DIR_DR;
            default: flip_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/filtru_senzori.sv
// Two-flop synchroniser followed by a debounce filter: the output vector only
// takes a new value once the synchronised vector has held it DEBOUNCE_CYC cycles.
module filtru_senzori #(
    parameter int unsigned WIDTH        = 5,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] senzori_raw,
    output logic [WIDTH-1:0] senzori_filt
);
    import pkg_masina::*;

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1) + 1;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_c;

    // Length of the current run of identical synchronised samples, saturating.
    always_comb begin
        run_c = CNT_W'(1);
        if (sync2_q == prev_q) begin
            if (run_q == CNT_W'(DEBOUNCE_CYC)) begin
                run_c = run_q;
            end else begin
                run_c = run_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            run_q        <= '0;
            senzori_filt <= '0;
        end else begin
            sync1_q <= senzori_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            run_q   <= run_c;
            if (run_c >= CNT_W'(DEBOUNCE_CYC)) begin
                senzori_filt <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/control_directie.sv
// Line-follower direction controller: steers two motor pairs from filtered line
// sensors, sweeps and reverses to recover a lost line, and drives turn signals.
module control_directie #(
    parameter int unsigned N_SENZORI    = 5,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned SEARCH_CYC   = 50_000_000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned BLINK_HALF   = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pornire,
    input  logic [N_SENZORI-1:0] senzori,
    output logic [1:0]           directie_driverA,
    output logic [1:0]           directie_driverB,
    output logic                 semnal_dreapta,
    output logic                 semnal_stanga,
    output logic [2:0]           stare
);
    import pkg_masina::*;

    localparam int unsigned C       = (N_SENZORI - 1) / 2;
    localparam int unsigned SEARCH_W = $clog2(SEARCH_CYC) + 1;
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRY) + 1;
    localparam int unsigned BLINK_W  = $clog2(BLINK_HALF) + 1;

    logic [N_SENZORI-1:0] filt;
    logic                 centru, dr, st, nimic;

    stare_t               state_q, state_n;
    ultima_t              ultima_q, ultima_n;
    logic [SEARCH_W-1:0]  cnt_q, cnt_n;
    logic [RETRY_W-1:0]   retry_q, retry_n;
    logic [BLINK_W-1:0]   blink_q;
    logic                 phase_q;
    comanda_t             cmd_q, cmd_n;

    filtru_senzori #(
        .WIDTH        (N_SENZORI),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_filtru (
        .clk          (clk),
        .rst          (rst),
        .senzori_raw  (senzori),
        .senzori_filt (filt)
    );

    assign centru = filt[C];
    assign dr     = |filt[C-1:0];
    assign st     = |filt[N_SENZORI-1:C+1];
    assign nimic  = ~|filt;

    // Next state, counters and last-seen side.
    always_comb begin
        state_n  = state_q;
        ultima_n = ultima_q;
        cnt_n    = cnt_q + SEARCH_W'(1);
        retry_n  = retry_q;
        case (state_q)
            ST_FOLLOW: begin
                cnt_n = '0;
                if (nimic) begin
                    state_n = (ultima_q != DIR_NONE) ? ST_SEARCH : ST_REVERSE;
                end else if (dr && !st) begin
                    ultima_n = DIR_DR;
                end else if (st && !dr) begin
                    ultima_n = DIR_ST;
                end
            end
            ST_SEARCH: begin
                if (!nimic) begin
                    state_n = ST_FOLLOW;
                    retry_n = '0;
                    cnt_n   = '0;
                end else if (cnt_q == SEARCH_W'(SEARCH_CYC - 1)) begin
                    state_n  = ST_REVERSE;
                    ultima_n = flip_dir(ultima_q);
                    cnt_n    = '0;
                end
            end
            ST_REVERSE: begin
                if (!nimic) begin
                    state_n = ST_FOLLOW;
                    retry_n = '0;
                    cnt_n   = '0;
                end else if (cnt_q == SEARCH_W'(SEARCH_CYC - 1)) begin
                    cnt_n = '0;
                    if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                        state_n = ST_STOP;
                        retry_n = '0;
                    end else begin
                        state_n = ST_SEARCH;
                        retry_n = retry_q + RETRY_W'(1);
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                retry_n = '0;
                if (pornire && !nimic) begin
                    state_n = ST_FOLLOW;
                end
            end
        endcase
        if (!pornire) begin
            state_n = ST_STOP;
            cnt_n   = '0;
            retry_n = '0;
        end
    end

    // Motor and signal command for the state being entered.
    always_comb begin
        cmd_n.drv_a  = MOT_HALT;
        cmd_n.drv_b  = MOT_HALT;
        cmd_n.sig_dr = 1'b0;
        cmd_n.sig_st = 1'b0;
        case (state_n)
            ST_FOLLOW: begin
                if (dr && !st) begin
                    cmd_n.drv_a  = MOT_REV;
                    cmd_n.drv_b  = MOT_FWD;
                    cmd_n.sig_dr = phase_q;
                end else if (st && !dr) begin
                    cmd_n.drv_a  = MOT_FWD;
                    cmd_n.drv_b  = MOT_REV;
                    cmd_n.sig_st = phase_q;
                end else if (centru || (dr && st)) begin
                    cmd_n.drv_a = MOT_FWD;
                    cmd_n.drv_b = MOT_FWD;
                end
            end
            ST_SEARCH: begin
                if (ultima_n == DIR_DR) begin
                    cmd_n.drv_a  = MOT_REV;
                    cmd_n.drv_b  = MOT_FWD;
                    cmd_n.sig_dr = phase_q;
                end else if (ultima_n == DIR_ST) begin
                    cmd_n.drv_a  = MOT_FWD;
                    cmd_n.drv_b  = MOT_REV;
                    cmd_n.sig_st = phase_q;
                end else begin
                    cmd_n.drv_a = MOT_FWD;
                    cmd_n.drv_b = MOT_FWD;
                end
            end
            ST_REVERSE: begin
                cmd_n.drv_a  = MOT_REV;
                cmd_n.drv_b  = MOT_REV;
                cmd_n.sig_dr = phase_q;
                cmd_n.sig_st = phase_q;
            end
            default: begin
                cmd_n.sig_dr = phase_q;
                cmd_n.sig_st = phase_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_STOP;
            ultima_q <= DIR_NONE;
            cnt_q    <= '0;
            retry_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_n;
            ultima_q <= ultima_n;
            cnt_q    <= cnt_n;
            retry_q  <= retry_n;
            cmd_q    <= cmd_n;
            // Free-running blink phase.
            if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
                blink_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                blink_q <= blink_q + BLINK_W'(1);
            end
        end
    end

    assign directie_driverA = cmd_q.drv_a;
    assign directie_driverB = cmd_q.drv_b;
    assign semnal_dreapta   = cmd_q.sig_dr;
    assign semnal_stanga    = cmd_q.sig_st;
    assign stare            = 3'(state_q);

endmodule

// File: tb/tb_control_directie.sv
// Scoreboard bench for control_directie: stimulus queues time-stamped expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_control_directie;

    localparam int unsigned NS = 5;
    localparam int unsigned DB = 2;
    localparam int unsigned SC = 8;
    localparam int unsigned MR = 2;
    localparam int unsigned BH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pornire;
    logic [4:0] senzori;
    logic [1:0] drv_a;
    logic [1:0] drv_b;
    logic       sig_dr;
    logic       sig_st;
    logic [2:0] stare;

    control_directie #(
        .N_SENZORI    (NS),
        .DEBOUNCE_CYC (DB),
        .SEARCH_CYC   (SC),
        .MAX_RETRY    (MR),
        .BLINK_HALF   (BH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pornire          (pornire),
        .senzori          (senzori),
        .directie_driverA (drv_a),
        .directie_driverB (drv_b),
        .semnal_dreapta   (sig_dr),
        .semnal_stanga    (sig_st),
        .stare            (stare)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         when;
        logic [1:0] a;
        logic [1:0] b;
        logic       sd;
        logic       ss;
        logic [2:0] st;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   rb     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Blink phase as seen on the registered signal outputs at edge e.
    function automatic logic ph(input int e);
        if (e <= rb) return 1'b0;
        return 1'(((e - 1 - rb) / int'(BH)) % 2);
    endfunction

    task automatic expect_at(input int e, input logic [1:0] a, input logic [1:0] b,
                             input logic sd, input logic ss, input logic [2:0] st,
                             input string nm);
        exp_t x;
        x.when = e; x.a = a; x.b = b; x.sd = sd; x.ss = ss; x.st = st; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic exp_straight(input int e, input string nm);
        expect_at(e, 2'b10, 2'b10, 1'b0, 1'b0, 3'd0, nm);
    endtask
    task automatic exp_right(input int e, input string nm);
        expect_at(e, 2'b01, 2'b10, ph(e), 1'b0, 3'd0, nm);
    endtask
    task automatic exp_left(input int e, input string nm);
        expect_at(e, 2'b10, 2'b01, 1'b0, ph(e), 3'd0, nm);
    endtask
    task automatic exp_search_dr(input int e, input string nm);
        expect_at(e, 2'b01, 2'b10, ph(e), 1'b0, 3'd1, nm);
    endtask
    task automatic exp_search_st(input int e, input string nm);
        expect_at(e, 2'b10, 2'b01, 1'b0, ph(e), 3'd1, nm);
    endtask
    task automatic exp_rev(input int e, input string nm);
        expect_at(e, 2'b01, 2'b01, ph(e), ph(e), 3'd2, nm);
    endtask
    task automatic exp_stop(input int e, input string nm);
        expect_at(e, 2'b00, 2'b00, ph(e), ph(e), 3'd3, nm);
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin : monitor
        exp_t x;
        while (sb.size() > 0 && sb[0].when <= cyc) begin
            x = sb.pop_front();
            checks++;
            if (x.when < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                         x.name, x.when, cyc);
            end else if ({drv_a, drv_b, sig_dr, sig_st, stare} !==
                         {x.a, x.b, x.sd, x.ss, x.st}) begin
                errors++;
                $display("FAIL %s @%0d: got A=%b B=%b dr=%b st=%b stare=%0d, want A=%b B=%b dr=%b st=%b stare=%0d",
                         x.name, cyc, drv_a, drv_b, sig_dr, sig_st, stare,
                         x.a, x.b, x.sd, x.ss, x.st);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at(input int t);
        while (cyc < t) tick(1);
    endtask

    initial begin
        int k;
        rst = 1'b1; pornire = 1'b0; senzori = 5'b00000;
        tick(2);
        rb = cyc;
        expect_at(cyc, 2'b00, 2'b00, 1'b0, 1'b0, 3'd3, "reset");

        // Centre line: FOLLOW straight exactly DB+3 edges later.
        rst = 1'b0; pornire = 1'b1; senzori = 5'b00100; k = cyc;
        exp_stop(k + 4, "pre_follow");
        exp_straight(k + 5, "follow_centre");

        // Line on the left side: left pivot, left signal blinking.
        at(k + 6); senzori = 5'b01100; k = cyc;
        exp_straight(k + 4, "left_latency");
        for (int i = 5; i <= 12; i++) exp_left(k + i, "left_blink");

        // One-cycle glitch to a right-side pattern must not propagate.
        at(k + 13); senzori = 5'b00010; tick(1); senzori = 5'b01100;
        for (int i = 14; i <= 22; i++) exp_left(k + i, "glitch");

        // Line on the right side: right pivot, remembers DR.
        at(k + 23); senzori = 5'b00110; k = cyc;
        exp_left(k + 4, "right_latency");
        exp_right(k + 5, "right_turn");

        // Line lost: two sweep/reverse rounds, then STOP.
        at(k + 6); senzori = 5'b00000; k = cyc;
        exp_right(k + 4, "lost_latency");
        for (int i = 5;  i <= 12; i++) exp_search_dr(k + i, "search_dr");
        for (int i = 13; i <= 20; i++) exp_rev(k + i, "reverse1");
        for (int i = 21; i <= 28; i++) exp_search_st(k + i, "search_st");
        for (int i = 29; i <= 36; i++) exp_rev(k + i, "reverse2");
        for (int i = 37; i <= 44; i++) exp_stop(k + i, "stop_hazard");

        // Line back: STOP -> FOLLOW.
        at(k + 45); senzori = 5'b00100; k = cyc;
        exp_stop(k + 4, "stop_hold");
        exp_straight(k + 5, "stop_to_follow");

        // Reset pulse in the middle of a sweep.
        at(k + 6); senzori = 5'b00000; k = cyc;
        exp_straight(k + 4, "lost2_latency");
        for (int i = 5; i <= 7; i++) exp_search_dr(k + i, "search_before_rst");
        at(k + 7); rst = 1'b1; tick(1);
        rb = cyc;
        expect_at(cyc, 2'b00, 2'b00, 1'b0, 1'b0, 3'd3, "rst_mid_search");
        rst = 1'b0; senzori = 5'b00100; k = cyc;
        for (int i = 1; i <= 4; i++) exp_stop(k + i, "after_rst");
        exp_straight(k + 5, "follow_after_rst");

        // No remembered side after reset: loss goes straight to REVERSE.
        at(k + 6); senzori = 5'b00000; k = cyc;
        exp_straight(k + 4, "lost3_latency");
        for (int i = 5; i <= 7; i++) exp_rev(k + i, "reverse_none");
        at(k + 7); pornire = 1'b0;
        exp_stop(k + 8, "pornire_off");

        // Re-enable, re-acquire, lose again: a full-length REVERSE from cleared counters.
        at(k + 8); pornire = 1'b1; senzori = 5'b00100; k = cyc;
        exp_stop(k + 4, "reenable_hold");
        exp_straight(k + 5, "reenable_follow");
        at(k + 6); senzori = 5'b00000; k = cyc;
        for (int i = 5; i <= 12; i++) exp_rev(k + i, "reverse_full");

        at(k + 13);
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
            errors += sb.size();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
